// File: rtl/trap_controller.sv
// M/U-mode trap unit: decodes ecall/ebreak/mret/illegal, arbitrates interrupts, owns the trap CSRs
// and privilege mode, and sequences a two-cycle flush/redirect towards fetch.
module trap_controller #(
   parameter int XLEN      = 32,
   parameter int NUM_IRQ   = 3,
   parameter bit U_MODE_EN = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [1:0]         i_EXCOp,
   input  logic [2:0]         i_funct3,
   input  logic [11:0]        i_funct12,
   input  logic [XLEN-1:0]    i_pc,
   input  logic [XLEN-1:0]    i_tval,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic               i_csrWe,
   input  logic [11:0]        i_csrAddr,
   input  logic [XLEN-1:0]    i_csrWdata,
   output logic [XLEN-1:0]    o_csrRdata,
   output logic               o_flush,
   output logic               o_stall,
   output logic               o_redirect,
   output logic [XLEN-1:0]    o_redirectPc,
   output logic [1:0]         o_nowPrivMode
);

   localparam logic [1:0] PRIV_M  = 2'b11;
   localparam logic [1:0] PRIV_U  = 2'b00;
   localparam logic [1:0] MPP_RET = U_MODE_EN ? PRIV_U : PRIV_M;

   typedef enum logic [1:0] {S_IDLE, S_TRAP, S_REDIR} state_t;

   // irq[0..2] are the standard MSI/MTI/MEI lines; the rest map onto platform causes from 16.
   function automatic logic [4:0] irq_cause(input int k);
      if (k == 0)      return 5'd3;
      else if (k == 1) return 5'd7;
      else if (k == 2) return 5'd11;
      else             return 5'(16 + k - 3);
   endfunction

   function automatic logic [XLEN-1:0] irq_bits();
      logic [XLEN-1:0] m;
      m = '0;
      for (int k = 0; k < NUM_IRQ; k++) m[irq_cause(k)] = 1'b1;
      return m;
   endfunction

   localparam logic [XLEN-1:0] MIE_MASK = irq_bits();

   state_t            state_q, state_d;
   logic [1:0]        priv_q, mpp_q;
   logic              mstatus_mie_q, mstatus_mpie_q;
   logic [XLEN-1:0]   mepc_q, mcause_q, mtval_q, mtvec_q, mie_q;
   logic              pend_mret_q, pend_intr_q;
   logic [4:0]        pend_cause_q;
   logic [XLEN-1:0]   pend_pc_q, pend_tval_q;

   logic              irq_pend, irq_en, take_irq, exc, illegal, mret_req, event_req, csr_we_eff;
   logic [4:0]        irq_sel, exc_cause;
   logic [XLEN-1:0]   exc_tval, trap_base, redirect_target;

   // Later (higher-index) lines overwrite earlier ones, so the highest pending index wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
      irq_pend = 1'b0;
      irq_sel  = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         if (i_irq[k] && mie_q[irq_cause(k)]) begin
            irq_pend = 1'b1;
            irq_sel  = irq_cause(k);
         end
      end
   end

   assign irq_en   = (priv_q == PRIV_M && mstatus_mie_q) || (priv_q == PRIV_U);
   assign take_irq = i_valid && (state_q == S_IDLE) && irq_pend && irq_en;

   always_comb begin
      exc       = 1'b0;
      illegal   = 1'b0;
      mret_req  = 1'b0;
      exc_cause = '0;
      exc_tval  = '0;
      if (i_valid && state_q == S_IDLE) begin
         case (i_EXCOp)
            2'b10: illegal = 1'b1;
            2'b01: begin
               if (i_funct3 == 3'b000) begin
                  case (i_funct12)
                     12'h000: begin
                        exc       = 1'b1;
                        exc_cause = (priv_q == PRIV_U) ? 5'd8 : 5'd11;
                     end
                     12'h001: begin
                        exc       = 1'b1;
                        exc_cause = 5'd3;
                        exc_tval  = i_pc;
                     end
                     12'h302: begin
                        if (priv_q == PRIV_M) mret_req = 1'b1;
                        else                  illegal  = 1'b1;
                     end
                     default: illegal = 1'b1;
                  endcase
               end
            end
            default: ;
         endcase
      end
      if (illegal) begin
         exc       = 1'b1;
         exc_cause = 5'd2;
         exc_tval  = i_tval;
      end
   end

   assign event_req  = take_irq || exc || mret_req;
   assign csr_we_eff = i_csrWe && (state_q == S_IDLE) && !event_req;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (event_req) state_d = S_TRAP;
         S_TRAP:  state_d = S_REDIR;
         S_REDIR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

   always_comb begin
      redirect_target = trap_base;
      if (pend_mret_q)
         redirect_target = mepc_q;
      else if (mtvec_q[1:0] == 2'b01 && pend_intr_q)
         redirect_target = trap_base + {{(XLEN-7){1'b0}}, pend_cause_q, 2'b00};
   end

   always_comb begin
      o_flush      = (state_q == S_TRAP);
      o_stall      = (state_q != S_IDLE);
      o_redirect   = (state_q == S_REDIR);
      o_redirectPc = (state_q == S_REDIR) ? redirect_target : '0;
   end

   // Snapshot of the triggering instruction; consumed by the TRAP and REDIR cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_mret_q  <= 1'b0;
         pend_intr_q  <= 1'b0;
         pend_cause_q <= '0;
         pend_pc_q    <= '0;
         pend_tval_q  <= '0;
      end else if (state_q == S_IDLE && event_req) begin
         pend_mret_q  <= mret_req && !take_irq;
         pend_intr_q  <= take_irq;
         pend_cause_q <= take_irq ? irq_sel : exc_cause;
         pend_pc_q    <= i_pc;
         pend_tval_q  <= take_irq ? '0 : exc_tval;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         priv_q         <= PRIV_M;
         mpp_q          <= PRIV_M;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mtvec_q        <= '0;
         mie_q          <= '0;
      end else if (state_q == S_TRAP) begin
         if (pend_mret_q) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            priv_q         <= U_MODE_EN ? mpp_q : PRIV_M;
            mpp_q          <= MPP_RET;
         end else begin
            mepc_q         <= {pend_pc_q[XLEN-1:2], 2'b00};
            mcause_q       <= {pend_intr_q, {(XLEN-6){1'b0}}, pend_cause_q};
            mtval_q        <= pend_tval_q;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            mpp_q          <= priv_q;
            priv_q         <= PRIV_M;
         end
      end else if (csr_we_eff) begin
         case (i_csrAddr)
            12'h300: begin
               mstatus_mie_q  <= i_csrWdata[3];
               mstatus_mpie_q <= i_csrWdata[7];
               mpp_q          <= (U_MODE_EN && i_csrWdata[12:11] != 2'b11) ? PRIV_U : PRIV_M;
            end
            12'h304: mie_q    <= i_csrWdata & MIE_MASK;
            12'h305: mtvec_q  <= i_csrWdata;
            12'h341: mepc_q   <= {i_csrWdata[XLEN-1:2], 2'b00};
            12'h342: mcause_q <= i_csrWdata;
            12'h343: mtval_q  <= i_csrWdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      o_csrRdata = '0;
      case (i_csrAddr)
         12'h300: begin
            o_csrRdata[3]     = mstatus_mie_q;
            o_csrRdata[7]     = mstatus_mpie_q;
            o_csrRdata[12:11] = mpp_q;
         end
         12'h304: o_csrRdata = mie_q;
         12'h305: o_csrRdata = mtvec_q;
         12'h341: o_csrRdata = mepc_q;
         12'h342: o_csrRdata = mcause_q;
         12'h343: o_csrRdata = mtval_q;
         12'h344: for (int k = 0; k < NUM_IRQ; k++) o_csrRdata[irq_cause(k)] = i_irq[k];
         default: ;
      endcase
   end

   assign o_nowPrivMode = priv_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: expected redirect targets are queued when an event is
// issued and popped when the redirect appears; CSR side effects are compared inline.
module tb_trap_controller;

   logic        i_clk, i_rst, i_valid, i_csrWe;
   logic [1:0]  i_EXCOp;
   logic [2:0]  i_funct3, i_irq;
   logic [11:0] i_funct12, i_csrAddr;
   logic [31:0] i_pc, i_tval, i_csrWdata;
   logic [31:0] o_csrRdata, o_redirectPc;
   logic        o_flush, o_stall, o_redirect;
   logic [1:0]  o_nowPrivMode;

   logic [31:0] sb_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   trap_controller dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_EXCOp(i_EXCOp),
      .i_funct3(i_funct3), .i_funct12(i_funct12), .i_pc(i_pc), .i_tval(i_tval),
      .i_irq(i_irq), .i_csrWe(i_csrWe), .i_csrAddr(i_csrAddr), .i_csrWdata(i_csrWdata),
      .o_csrRdata(o_csrRdata), .o_flush(o_flush), .o_stall(o_stall), .o_redirect(o_redirect),
      .o_redirectPc(o_redirectPc), .o_nowPrivMode(o_nowPrivMode)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic drive_idle();
      i_valid = 0; i_EXCOp = 0; i_funct3 = 0; i_funct12 = 0; i_pc = 0; i_tval = 0;
      i_csrWe = 0; i_csrAddr = 0; i_csrWdata = 0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      i_valid = 1; i_EXCOp = 2'b01; i_funct3 = 3'b001; i_funct12 = a;
      i_csrWe = 1; i_csrAddr = a; i_csrWdata = d;
      @(negedge i_clk);
      drive_idle();
   endtask

   task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
      i_csrAddr = a;
      #1 d = o_csrRdata;
   endtask

   // Presents one instruction for a cycle; returns at the negedge of the following (TRAP) cycle.
   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] f12,
                        input logic [31:0] pc, input logic [31:0] tval,
                        input logic we, input logic [11:0] wa, input logic [31:0] wd);
      i_valid = 1; i_EXCOp = op; i_funct3 = f3; i_funct12 = f12; i_pc = pc; i_tval = tval;
      i_csrWe = we; i_csrAddr = wa; i_csrWdata = wd;
      @(negedge i_clk);
      drive_idle();
   endtask

   task automatic wait_redirect(output logic [31:0] pc, output bit seen);
      seen = 0;
      pc   = 'x;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge i_clk);
         if (o_redirect) begin
            seen = 1;
            pc   = o_redirectPc;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      i_rst = 1; i_irq = 0; drive_idle();
      repeat (2) @(negedge i_clk);
      vectors++;
      if ({o_flush, o_stall, o_redirect} !== 3'b000 || o_redirectPc !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got f/s/r=%b%b%b pc=%h, want 000 pc=0",
                  o_flush, o_stall, o_redirect, o_redirectPc);
      end
      i_rst = 0;
      @(negedge i_clk);
      vectors++;
      if (o_nowPrivMode !== 2'b11) begin
         miscompares++; $display("FAIL reset_priv: got %b, want 11", o_nowPrivMode);
      end
      csr_rd(12'h300, d);
      vectors++;
      if (d !== 32'h1800) begin
         miscompares++; $display("FAIL reset_mstatus: got %h, want 00001800", d);
      end
   endtask

   task automatic test_mret();
      logic [31:0] d, pc, exp;
      bit seen;
      csr_wr(12'h305, 32'h200);
      csr_wr(12'h300, 32'h80);
      csr_wr(12'h341, 32'h104);
      sb_q.push_back(32'h104);
      issue(2'b01, 3'b000, 12'h302, 32'h80, 32'h30200073, 1'b0, 12'h0, 32'h0);
      vectors++;
      if ({o_flush, o_stall, o_redirect} !== 3'b110) begin
         miscompares++;
         $display("FAIL mret_flush: got f/s/r=%b%b%b, want 110", o_flush, o_stall, o_redirect);
      end
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL mret_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h300, d);
      vectors++;
      if (d !== 32'h88 || o_nowPrivMode !== 2'b00) begin
         miscompares++;
         $display("FAIL mret_state: got mstatus=%h priv=%b, want 00000088 priv=00", d, o_nowPrivMode);
      end
      // mret from U is illegal
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h302, 32'h108, 32'h30200073, 1'b0, 12'h0, 32'h0);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL mret_u_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h342, d);
      vectors++;
      if (d !== 32'h2) begin
         miscompares++; $display("FAIL mret_u_mcause: got %h, want 00000002", d);
      end
      csr_rd(12'h343, d);
      vectors++;
      if (d !== 32'h30200073 || o_nowPrivMode !== 2'b11) begin
         miscompares++;
         $display("FAIL mret_u_mtval: got %h priv=%b, want 30200073 priv=11", d, o_nowPrivMode);
      end
   endtask

   task automatic test_ecall_u();
      logic [31:0] d, pc, exp;
      bit seen;
      csr_wr(12'h300, 32'h0);
      csr_wr(12'h341, 32'h104);
      sb_q.push_back(32'h104);
      issue(2'b01, 3'b000, 12'h302, 32'h90, 32'h0, 1'b0, 12'h0, 32'h0);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      @(negedge i_clk);
      vectors++;
      if (!seen || pc !== exp || o_nowPrivMode !== 2'b00) begin
         miscompares++;
         $display("FAIL enter_u: got pc=%h priv=%b, want %h priv=00", pc, o_nowPrivMode, exp);
      end
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h000, 32'h100, 32'h0, 1'b0, 12'h0, 32'h0);
      vectors++;
      if (o_flush !== 1'b1 || o_redirect !== 1'b0) begin
         miscompares++; $display("FAIL ecall_flush: got f=%b r=%b, want f=1 r=0", o_flush, o_redirect);
      end
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL ecall_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h342, d);
      vectors++;
      if (d !== 32'h8 || o_nowPrivMode !== 2'b11) begin
         miscompares++; $display("FAIL ecall_mcause: got %h priv=%b, want 00000008 priv=11", d, o_nowPrivMode);
      end
      csr_rd(12'h341, d);
      vectors++;
      if (d !== 32'h100) begin
         miscompares++; $display("FAIL ecall_mepc: got %h, want 00000100", d);
      end
   endtask

   task automatic test_csr_write_dropped();
      logic [31:0] d, pc, exp;
      bit seen;
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h000, 32'h200, 32'h0, 1'b1, 12'h305, 32'h400);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL drop_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h305, d);
      vectors++;
      if (d !== 32'h200) begin
         miscompares++; $display("FAIL drop_mtvec: got %h, want 00000200", d);
      end
      csr_rd(12'h342, d);
      vectors++;
      if (d !== 32'hB) begin
         miscompares++; $display("FAIL ecall_m_mcause: got %h, want 0000000b", d);
      end
   endtask

   task automatic test_ebreak_illegal();
      logic [31:0] d, pc, exp;
      bit seen;
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h001, 32'h123, 32'h0, 1'b0, 12'h0, 32'h0);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      @(negedge i_clk);
      csr_rd(12'h341, d);
      vectors++;
      if (!seen || pc !== exp || d !== 32'h120) begin
         miscompares++; $display("FAIL ebreak_mepc: got pc=%h mepc=%h, want %h mepc=00000120", pc, d, exp);
      end
      csr_rd(12'h343, d);
      vectors++;
      if (d !== 32'h123) begin
         miscompares++; $display("FAIL ebreak_mtval: got %h, want 00000123", d);
      end
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h105, 32'h140, 32'h10500073, 1'b0, 12'h0, 32'h0);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      @(negedge i_clk);
      csr_rd(12'h342, d);
      vectors++;
      if (!seen || pc !== exp || d !== 32'h2) begin
         miscompares++; $display("FAIL illegal_f12: got pc=%h mcause=%h, want %h mcause=00000002", pc, d, exp);
      end
   endtask

   task automatic test_interrupt();
      logic [31:0] d, pc, exp;
      bit seen;
      csr_wr(12'h305, 32'h201);
      csr_wr(12'h304, 32'h888);
      csr_wr(12'h300, 32'h1808);
      i_irq = 3'b110;
      csr_rd(12'h344, d);
      vectors++;
      if (d !== 32'h880) begin
         miscompares++; $display("FAIL mip_read: got %h, want 00000880", d);
      end
      sb_q.push_back(32'h22C);
      issue(2'b00, 3'b000, 12'h000, 32'h400, 32'h0, 1'b0, 12'h0, 32'h0);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL irq_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h342, d);
      vectors++;
      if (d !== 32'h8000000B) begin
         miscompares++; $display("FAIL irq_mcause: got %h, want 8000000b", d);
      end
      csr_rd(12'h300, d);
      vectors++;
      if (d !== 32'h1880) begin
         miscompares++; $display("FAIL irq_mstatus: got %h, want 00001880", d);
      end
      i_irq = 3'b000;
   endtask

   task automatic test_irq_beats_exception();
      logic [31:0] d, pc, exp;
      bit seen;
      csr_wr(12'h300, 32'h1808);
      i_irq = 3'b010;
      sb_q.push_back(32'h21C);
      issue(2'b10, 3'b000, 12'h000, 32'h500, 32'hFFFFFFFF, 1'b0, 12'h0, 32'h0);
      i_irq = 3'b000;
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL irq_win_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h342, d);
      vectors++;
      if (d !== 32'h80000007) begin
         miscompares++; $display("FAIL irq_win_mcause: got %h, want 80000007", d);
      end
      csr_rd(12'h343, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL irq_win_mtval: got %h, want 00000000", d);
      end
      // exceptions ignore vectored mode
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h001, 32'h600, 32'h0, 1'b0, 12'h0, 32'h0);
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL vec_exc_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
   endtask

   task automatic test_csr_misc();
      logic [31:0] d;
      csr_wr(12'h344, 32'hFFFFFFFF);
      csr_rd(12'h344, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL mip_write: got %h, want 00000000", d);
      end
      csr_wr(12'h7C0, 32'h55);
      csr_rd(12'h7C0, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL unmapped_read: got %h, want 00000000", d);
      end
      csr_wr(12'h300, 32'h1000);
      csr_rd(12'h300, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL mpp_10_as_u: got %h, want 00000000", d);
      end
      csr_wr(12'h341, 32'h107);
      csr_rd(12'h341, d);
      vectors++;
      if (d !== 32'h104) begin
         miscompares++; $display("FAIL mepc_align: got %h, want 00000104", d);
      end
      i_valid = 1; i_EXCOp = 2'b00; i_pc = 32'h700;
      @(negedge i_clk);
      drive_idle();
      vectors++;
      if ({o_flush, o_stall} !== 2'b00) begin
         miscompares++; $display("FAIL no_event: got f/s=%b%b, want 00", o_flush, o_stall);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, pc, exp;
      bit seen;
      csr_wr(12'h305, 32'h200);
      sb_q.push_back(32'h200);
      sb_q.push_back(32'h200);
      issue(2'b01, 3'b000, 12'h000, 32'h300, 32'h0, 1'b0, 12'h0, 32'h0);
      // noise during TRAP must be ignored
      i_valid = 1; i_EXCOp = 2'b10; i_tval = 32'hDEAD; i_pc = 32'h999;
      i_csrWe = 1; i_csrAddr = 12'h305; i_csrWdata = 32'h400;
      @(negedge i_clk);
      drive_idle();
      vectors++;
      exp = sb_q.pop_front();
      if (o_redirect !== 1'b1 || o_redirectPc !== exp) begin
         miscompares++; $display("FAIL b2b_first: got r=%b pc=%h, want r=1 %h", o_redirect, o_redirectPc, exp);
      end
      i_valid = 1; i_EXCOp = 2'b01; i_funct3 = 3'b000; i_funct12 = 12'h000; i_pc = 32'h304;
      csr_rd(12'h343, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL b2b_mtval: got %h, want 00000000", d);
      end
      repeat (2) @(negedge i_clk);
      drive_idle();
      vectors++;
      if (o_flush !== 1'b1) begin
         miscompares++; $display("FAIL b2b_second_flush: got %b, want 1", o_flush);
      end
      wait_redirect(pc, seen);
      exp = sb_q.pop_front();
      vectors++;
      if (!seen || pc !== exp) begin
         miscompares++; $display("FAIL b2b_second_redirect: got %h (seen=%0d), want %h", pc, seen, exp);
      end
      @(negedge i_clk);
      csr_rd(12'h341, d);
      vectors++;
      if (d !== 32'h304) begin
         miscompares++; $display("FAIL b2b_mepc: got %h, want 00000304", d);
      end
      csr_rd(12'h305, d);
      vectors++;
      if (d !== 32'h200) begin
         miscompares++; $display("FAIL b2b_mtvec: got %h, want 00000200", d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit seen;
      issue(2'b01, 3'b000, 12'h000, 32'h700, 32'h0, 1'b0, 12'h0, 32'h0);
      i_rst = 1;
      @(posedge i_clk);
      #1;
      vectors++;
      if ({o_flush, o_stall, o_redirect} !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_mid_idle: got f/s/r=%b%b%b, want 000", o_flush, o_stall, o_redirect);
      end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         i_rst = 0;
         if (o_redirect) seen = 1;
      end
      vectors++;
      if (seen) begin
         miscompares++; $display("FAIL rst_mid_redirect: got redirect=1, want 0");
      end
      csr_rd(12'h341, d);
      vectors++;
      if (d !== 32'h0 || o_nowPrivMode !== 2'b11) begin
         miscompares++; $display("FAIL rst_mid_state: got mepc=%h priv=%b, want 00000000 priv=11", d, o_nowPrivMode);
      end
   endtask

   initial begin
      test_reset();
      test_mret();
      test_ecall_u();
      test_csr_write_dropped();
      test_ebreak_illegal();
      test_interrupt();
      test_irq_beats_exception();
      test_csr_misc();
      test_back_to_back();
      test_reset_mid();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++; $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
